// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - state codes, mux selects and trap causes for the multi-cycle sequencer
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5,
        ST_HALT   = 3'd6,
        ST_UNUSED = 3'd7
    } state_t;

    localparam logic [1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd1;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd2;
    localparam logic [1:0] PC_SEL_TRAP   = 2'd3;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_LOAD = 2'd1;
    localparam logic [1:0] WSEL_PC4  = 2'd2;
    localparam logic [1:0] WSEL_CSR  = 2'd3;

    localparam logic [3:0] CAUSE_NONE        = 4'd0;
    localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

    // Register-file write source; load wins over jump, jump over CSR.
    function automatic logic [1:0] wb_wsel(input logic is_load, input logic is_jump,
                                           input logic is_csr);
        if (is_load)      return WSEL_LOAD;
        else if (is_jump) return WSEL_PC4;
        else if (is_csr)  return WSEL_CSR;
        else              return WSEL_ALU;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction and data memory request/ack bundle
// imem_req/imem_ack : fetch handshake
// dmem_req/dmem_we/dmem_ack : data access handshake (dmem_we=1 store)
// master = sequencer side, slave = memory side
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl_bus_watchdog.sv
// rtl/multicycle_ctrl_bus_watchdog.sv - request-without-ack cycle counter with expiry flag
// clock, reset_n : core clock, async active-low reset
// clear          : hold count at zero (outside any bus wait)
// enable         : a request cycle without ack; count advances
// expired        : this edge is the MEM_TIMEOUT-th cycle without ack
module multicycle_ctrl_bus_watchdog #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam bit              ENABLED = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] LIMIT   = TO_W'(ENABLED ? MEM_TIMEOUT - 1 : 0);

    logic [TO_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TO_W'(1);
        end
    end

    // Flags the edge on which the count would reach MEM_TIMEOUT; an ack on
    // that same edge deasserts enable, so the ack wins.
    assign expired = ENABLED && enable && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle sequencer FETCH/DECODE/EXEC/MEM/WB with traps and halt
// clock, reset_n        : core clock, async active-low reset
// halt_req              : debug halt request, sampled in WB/TRAP/HALT
// bus                   : imem/dmem request-ack handshakes (master side)
// dec_valid, s_*        : decoder legality and class flags
// branch_taken          : branch compare result
// ir_we, pc_we, pc_sel  : IR/PC update controls
// rf_we, rf_wsel, csr_we: writeback controls
// trap, trap_cause      : trap pulse and sticky mcause
// halted, state, instret: debug status and retired count
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W       = 64,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 halt_req,
    multicycle_ctrl_if.master    bus,
    input  logic                 dec_valid,
    input  logic                 s_load,
    input  logic                 s_store,
    input  logic                 s_jump,
    input  logic                 s_branch,
    input  logic                 s_csr,
    input  logic                 branch_taken,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 rf_we,
    output logic [1:0]           rf_wsel,
    output logic                 csr_we,
    output logic                 trap,
    output logic [3:0]           trap_cause,
    output logic                 halted,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     instret
);

    state_t           state_q, state_d;
    logic [3:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q;

    logic wd_clear, wd_enable, wd_expired;

    logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c;
    logic       rf_we_c, csr_we_c, trap_c, halted_c;
    logic [1:0] pc_sel_c, rf_wsel_c;

    // One watchdog serves both waits: leaving FETCH/MEM clears it, so every
    // entry to a wait state starts from zero.
    assign wd_clear  = !(state_q == ST_FETCH || state_q == ST_MEM);
    assign wd_enable = (state_q == ST_FETCH && !bus.imem_ack) ||
                       (state_q == ST_MEM   && !bus.dmem_ack);

    multicycle_ctrl_bus_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == ST_WB) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = PC_SEL_PC4;
        rf_we_c    = 1'b0;
        rf_wsel_c  = WSEL_ALU;
        csr_we_c   = 1'b0;
        trap_c     = 1'b0;
        halted_c   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = ST_DECODE;
                end else if (wd_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_FETCH_FAULT;
                end
            end
            ST_DECODE: begin
                if (!dec_valid) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = (s_load || s_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = s_store;
                if (bus.dmem_ack) begin
                    state_d = ST_WB;
                end else if (wd_expired) begin
                    state_d = ST_TRAP;
                    cause_d = s_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                end
            end
            ST_WB: begin
                pc_we_c = 1'b1;
                if (s_jump)                       pc_sel_c = PC_SEL_JUMP;
                else if (s_branch && branch_taken) pc_sel_c = PC_SEL_BRANCH;
                else                              pc_sel_c = PC_SEL_PC4;
                rf_we_c   = !(s_store || s_branch);
                rf_wsel_c = wb_wsel(s_load, s_jump, s_csr);
                csr_we_c  = s_csr;
                state_d   = halt_req ? ST_HALT : ST_FETCH;
            end
            ST_TRAP: begin
                trap_c   = 1'b1;
                pc_we_c  = 1'b1;
                pc_sel_c = PC_SEL_TRAP;
                state_d  = halt_req ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                halted_c = 1'b1;
                state_d  = halt_req ? ST_HALT : ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // The state register already reads FETCH during reset, but FETCH
        // would still drive imem_req; force every strobe low while reset
        // is held so a handshake in flight is abandoned at once.
        if (!reset_n) begin
            imem_req_c = 1'b0;
            dmem_req_c = 1'b0;
            dmem_we_c  = 1'b0;
            ir_we_c    = 1'b0;
            pc_we_c    = 1'b0;
            rf_we_c    = 1'b0;
            csr_we_c   = 1'b0;
            trap_c     = 1'b0;
        end
    end

    assign bus.imem_req = imem_req_c;
    assign bus.dmem_req = dmem_req_c;
    assign bus.dmem_we  = dmem_we_c;
    assign ir_we        = ir_we_c;
    assign pc_we        = pc_we_c;
    assign pc_sel       = pc_sel_c;
    assign rf_we        = rf_we_c;
    assign rf_wsel      = rf_wsel_c;
    assign csr_we       = csr_we_c;
    assign trap         = trap_c;
    assign trap_cause   = cause_q;
    assign halted       = halted_c;
    assign state        = state_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W        = 8;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_JUMP = 4, K_CSR = 5;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic halt_req = 1'b0;
    logic dec_valid = 1'b0;
    logic s_load = 1'b0, s_store = 1'b0, s_jump = 1'b0, s_branch = 1'b0, s_csr = 1'b0;
    logic branch_taken = 1'b0;
    logic ir_we, pc_we, rf_we, csr_we, trap, halted;
    logic [1:0] pc_sel, rf_wsel;
    logic [3:0] trap_cause;
    logic [2:0] state;
    logic [CNT_W-1:0] instret;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .halt_req     (halt_req),
        .bus          (bus),
        .dec_valid    (dec_valid),
        .s_load       (s_load),
        .s_store      (s_store),
        .s_jump       (s_jump),
        .s_branch     (s_branch),
        .s_csr        (s_csr),
        .branch_taken (branch_taken),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .rf_wsel      (rf_wsel),
        .csr_we       (csr_we),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .halted       (halted),
        .state        (state),
        .instret      (instret)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]       st;
        logic             imem_req, dmem_req, dmem_we, ir_we, pc_we;
        logic [1:0]       pc_sel;
        logic             rf_we;
        logic [1:0]       rf_wsel;
        logic             csr_we, trap, halted;
        logic [3:0]       cause;
        logic [CNT_W-1:0] instret;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cnt_dreq = 0;
    int cnt_trap = 0;
    int m_instret = 0;
    logic [3:0] m_cause = 4'd0;
    exp_t exp_cur;
    bit exp_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t base(input logic [2:0] s);
        exp_t e;
        e = '{default: '0};
        e.st      = s;
        e.cause   = m_cause;
        e.instret = CNT_W'(m_instret);
        return e;
    endfunction

    task automatic post(input exp_t e);
        exp_cur   = e;
        exp_valid = 1'b1;
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    // Compare process: every cycle with a posted expectation.
    always @(negedge clock) begin
        if (exp_valid) begin
            chk("state",      64'(state),        64'(exp_cur.st));
            chk("imem_req",   64'(bus.imem_req), 64'(exp_cur.imem_req));
            chk("dmem_req",   64'(bus.dmem_req), 64'(exp_cur.dmem_req));
            if (exp_cur.dmem_req)
                chk("dmem_we", 64'(bus.dmem_we), 64'(exp_cur.dmem_we));
            chk("ir_we",      64'(ir_we),        64'(exp_cur.ir_we));
            chk("pc_we",      64'(pc_we),        64'(exp_cur.pc_we));
            chk("pc_sel",     64'(pc_sel),       64'(exp_cur.pc_sel));
            chk("rf_we",      64'(rf_we),        64'(exp_cur.rf_we));
            chk("rf_wsel",    64'(rf_wsel),      64'(exp_cur.rf_wsel));
            chk("csr_we",     64'(csr_we),       64'(exp_cur.csr_we));
            chk("trap",       64'(trap),         64'(exp_cur.trap));
            chk("halted",     64'(halted),       64'(exp_cur.halted));
            chk("trap_cause", 64'(trap_cause),   64'(exp_cur.cause));
            chk("instret",    64'(instret),      64'(exp_cur.instret));
            if (bus.dmem_req) cnt_dreq++;
            if (trap) cnt_trap++;
        end
    end

    task automatic finish_halt(input int h);
        exp_t e;
        for (int i = 0; i < h; i++) begin
            halt_req = (i < h - 1);
            e = base(ST_HALT);
            e.halted = 1'b1;
            post(e);
            adv();
        end
        halt_req = 1'b0;
    endtask

    task automatic take_trap(input logic [3:0] cause, input int h);
        exp_t e;
        m_cause = cause;
        if (h > 0) halt_req = 1'b1;
        e = base(ST_TRAP);
        e.trap   = 1'b1;
        e.pc_we  = 1'b1;
        e.pc_sel = 2'd3;
        post(e);
        adv();
        finish_halt(h);
    endtask

    // fack/mack: index of the request cycle carrying ack, -1 = never.
    task automatic run_instr(input int kind, input bit valid, input bit taken,
                             input int fack, input int mack, input int halt_cyc);
        bit ld, sv, jp, br, cs, ok;
        int n;
        exp_t e;
        ld = (kind == K_LOAD);  sv = (kind == K_STORE); jp = (kind == K_JUMP);
        br = (kind == K_BRANCH); cs = (kind == K_CSR);
        s_load = ld; s_store = sv; s_jump = jp; s_branch = br; s_csr = cs;
        dec_valid = valid; branch_taken = taken; halt_req = 1'b0;

        ok = (fack >= 0) && (fack < MEM_TIMEOUT);
        n  = ok ? fack + 1 : MEM_TIMEOUT;
        for (int i = 0; i < n; i++) begin
            bus.imem_ack = ok && (i == fack);
            e = base(ST_FETCH);
            e.imem_req = 1'b1;
            e.ir_we    = bus.imem_ack;
            post(e);
            adv();
        end
        bus.imem_ack = 1'b0;
        if (!ok) begin take_trap(4'd1, halt_cyc); return; end

        post(base(ST_DECODE));
        adv();
        if (!valid) begin take_trap(4'd2, halt_cyc); return; end

        if (halt_cyc > 0) halt_req = 1'b1;
        post(base(ST_EXEC));
        adv();

        if (ld || sv) begin
            ok = (mack >= 0) && (mack < MEM_TIMEOUT);
            n  = ok ? mack + 1 : MEM_TIMEOUT;
            for (int i = 0; i < n; i++) begin
                bus.dmem_ack = ok && (i == mack);
                e = base(ST_MEM);
                e.dmem_req = 1'b1;
                e.dmem_we  = sv;
                post(e);
                adv();
            end
            bus.dmem_ack = 1'b0;
            if (!ok) begin take_trap(sv ? 4'd7 : 4'd5, halt_cyc); return; end
        end

        e = base(ST_WB);
        e.pc_we   = 1'b1;
        e.pc_sel  = jp ? 2'd1 : (br && taken) ? 2'd2 : 2'd0;
        e.rf_we   = !(sv || br);
        e.rf_wsel = ld ? 2'd1 : jp ? 2'd2 : cs ? 2'd3 : 2'd0;
        e.csr_we  = cs;
        post(e);
        adv();
        m_instret = (m_instret + 1) % (1 << CNT_W);
        finish_halt(halt_cyc);
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset state",      64'(state),        64'd0);
        chk("reset imem_req",   64'(bus.imem_req), 64'd0);
        chk("reset instret",    64'(instret),      64'd0);
        chk("reset trap_cause", 64'(trap_cause),   64'd0);
        reset_n = 1'b1;

        // ADDI, ack in first fetch cycle
        run_instr(K_ALU, 1, 0, 0, 0, 0);
        chk("addi instret", 64'(instret), 64'd1);

        // LW, three wait cycles
        cnt_dreq = 0;
        run_instr(K_LOAD, 1, 0, 0, 3, 0);
        chk("lw dmem_req cycles", 64'(cnt_dreq), 64'd4);
        chk("lw instret", 64'(instret), 64'd2);

        // BEQ taken / not taken
        run_instr(K_BRANCH, 1, 1, 1, 0, 0);
        run_instr(K_BRANCH, 1, 0, 2, 0, 0);

        // illegal instruction
        cnt_trap = 0;
        run_instr(K_ALU, 0, 0, 0, 0, 0);
        chk("illegal cause",   64'(trap_cause), 64'd2);
        chk("illegal instret", 64'(instret),    64'd4);
        chk("illegal pulses",  64'(cnt_trap),   64'd1);

        // SW timeout, then SW with ack on the expiry edge
        cnt_dreq = 0;
        run_instr(K_STORE, 1, 0, 0, -1, 0);
        chk("sw timeout cause", 64'(trap_cause), 64'd7);
        chk("sw timeout req cycles", 64'(cnt_dreq), 64'd4);
        cnt_trap = 0;
        run_instr(K_STORE, 1, 0, 0, 3, 0);
        chk("sw late ack pulses", 64'(cnt_trap), 64'd0);
        chk("sw late ack instret", 64'(instret), 64'd5);

        // load and fetch timeouts
        run_instr(K_LOAD, 1, 0, 0, -1, 0);
        chk("lw timeout cause", 64'(trap_cause), 64'd5);
        run_instr(K_ALU, 1, 0, -1, 0, 0);
        chk("fetch timeout cause", 64'(trap_cause), 64'd1);

        // JAL, CSR, halt after load and after trap
        run_instr(K_JUMP, 1, 0, 0, 0, 0);
        run_instr(K_CSR, 1, 0, 3, 0, 0);
        run_instr(K_LOAD, 1, 0, 0, 1, 3);
        run_instr(K_ALU, 0, 0, 0, 0, 2);
        chk("halt instret", 64'(instret), 64'd8);

        // wrap instret through 15 -> 0
        for (int i = 0; i < 8; i++) run_instr(K_ALU, 1, 0, 0, 0, 0);
        chk("wrap instret", 64'(instret), 64'd0);
        run_instr(K_ALU, 1, 0, 0, 0, 0);

        // reset mid-FETCH
        exp_valid = 1'b0;
        bus.imem_ack = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid reset imem_req",   64'(bus.imem_req), 64'd0);
        chk("mid reset instret",    64'(instret),      64'd0);
        chk("mid reset state",      64'(state),        64'd0);
        chk("mid reset trap_cause", 64'(trap_cause),   64'd0);
        m_instret = 0;
        m_cause   = 4'd0;
        adv();
        reset_n = 1'b1;
        run_instr(K_ALU, 1, 0, 0, 0, 0);
        chk("post reset instret", 64'(instret), 64'd1);

        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
